divider5_seq: RTL

Sequential unsigned restoring divider. Performs quotient/remainder by repeated trial subtraction, which is the inverse operation of the team's add/subtract datapath: A + ~B with carry-in 1.
Produces one quotient bit per clock behind a start/busy/done handshake.
Sits beside the combinational adder/subtractor as the multi-cycle arithmetic unit of the lab datapath.

---
 rtl/divider_pkg.sv | 22 ++
 rtl/divider5_seq_trial_sub.sv | 25 ++
 rtl/divider5_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
//------------------------------------------------------------------------------
// divider_pkg : shared types and constants for the sequential divider
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 5;

  // Quotient reported for a zero divisor: every bit set.
  localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

`default_nettype wire

// File: rtl/divider5_seq_trial_sub.sv
//------------------------------------------------------------------------------
// trial_sub : combinational A + ~B + 1 subtractor with carry-out as no-borrow
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trial_sub #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             no_borrow_o
);

  logic [WIDTH:0] w_sum;

  // One extra bit carries the borrow; carry-out set means a >= b.
  assign w_sum       = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
  assign diff_o      = w_sum[WIDTH-1:0];
  assign no_borrow_o = w_sum[WIDTH];

endmodule

`default_nettype wire

// File: rtl/divider5_seq.sv
//------------------------------------------------------------------------------
// divider5_seq : restoring unsigned divider, one quotient bit per clock
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module divider5_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] qsh_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH-1:0] p_shift_d;
  logic [WIDTH-1:0] trial_d;
  logic             no_borrow_d;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] qsh_d;

  // Bring the next dividend bit into the partial remainder before the trial.
  assign p_shift_d = {p_q[WIDTH-2:0], dvd_q[WIDTH-1]};

  trial_sub #(
    .WIDTH(WIDTH)
  ) u_trial_sub (
    .a_i        (p_shift_d),
    .b_i        (dvs_q),
    .diff_o     (trial_d),
    .no_borrow_o(no_borrow_d)
  );

  assign p_d   = no_borrow_d ? trial_d : p_shift_d;
  assign qsh_d = {qsh_q[WIDTH-2:0], no_borrow_d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      p_q         <= '0;
      qsh_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          p_q   <= p_d;
          qsh_q <= qsh_d;
          dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          if (cnt_q == '0) begin
            state_q     <= FIN;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= qsh_d;
            remainder_q <= p_d;
            dbz_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            if (divisor == '0) begin
              state_q     <= FIN;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              p_q     <= '0;
              qsh_q   <= '0;
              cnt_q   <= CW'(WIDTH - 1);
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire
